// File: rtl/pio_loader_pkg.sv
// +----------------------------------------------------------------------+
// | pio_loader_pkg : shared types and constants for the PIO loader       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package pio_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROG = 2'd1,
    ST_CONF = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  localparam int ACT_INSTR_DEF = 1;
  localparam int ACT_PUSH_DEF  = 4;

  // Config word layout: {mindex[37:36], action[35:32], din[31:0]}
  localparam int CONF_MIDX_HI = 37;
  localparam int CONF_ACT_HI  = 35;
  localparam int CONF_DIN_HI  = 31;

endpackage

`default_nettype wire

// File: rtl/pio_loader.sv
// +----------------------------------------------------------------------+
// | pio_loader : streams program + config images into the PIO, then      |
// | hands the PIO command port to a host.                   Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module pio_loader
  import pio_loader_pkg::*;
#(
  parameter int PROG_LEN   = 32,
  parameter int CONF_DEPTH = 32,
  parameter int ACT_INSTR  = ACT_INSTR_DEF,
  parameter int ACT_PUSH   = ACT_PUSH_DEF
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic [5:0]  conf_len,
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [4:0]  conf_addr,
  input  logic [37:0] conf_data,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [5:0]  host_action,
  input  logic [1:0]  host_mindex,
  input  logic [31:0] host_din,
  input  logic [3:0]  tx_full,
  output logic [5:0]  pio_action,
  output logic [4:0]  pio_index,
  output logic [31:0] pio_din,
  output logic [1:0]  pio_mindex,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] c_prog_last = 5'(PROG_LEN - 1);

  state_e      state_q, state_d;
  logic [4:0]  p_q, p_d;
  logic [5:0]  conf_cnt_q, conf_cnt_d;
  logic [5:0]  len_q, len_d;

  // Stage 1: address issued last cycle, memory data arrives this cycle
  logic        s1_vld_q, s1_vld_d;
  logic        s1_conf_q, s1_conf_d;
  logic        s1_last_q, s1_last_d;
  logic [4:0]  s1_idx_q, s1_idx_d;

  logic [5:0]  act_q, act_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] din_q, din_d;
  logic [1:0]  midx_q, midx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        push_vld_q, push_vld_d;
  logic [1:0]  push_midx_q, push_midx_d;

  logic        w_is_push;
  logic        w_blocked;
  logic        w_host_ready;
  logic        w_accept;
  logic [5:0]  w_len_clamp;

  // tx_full lags an accepted push by a cycle, so the same FIFO is held off once more
  assign w_is_push    = (host_action == 6'(ACT_PUSH));
  assign w_blocked    = w_is_push &&
                        (tx_full[host_mindex] || (push_vld_q && (push_midx_q == host_mindex)));
  assign w_host_ready = (state_q == ST_RUN) && done_q && !start && !w_blocked;
  assign w_accept     = host_valid && w_host_ready;
  assign w_len_clamp  = (int'(conf_len) > CONF_DEPTH) ? 6'(CONF_DEPTH) : conf_len;

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    conf_cnt_d  = conf_cnt_q;
    len_d       = len_q;
    s1_vld_d    = 1'b0;
    s1_conf_d   = 1'b0;
    s1_last_d   = 1'b0;
    s1_idx_d    = 5'd0;
    act_d       = 6'd0;
    idx_d       = 5'd0;
    din_d       = 32'd0;
    midx_d      = 2'd0;
    busy_d      = busy_q;
    done_d      = done_q;
    push_vld_d  = w_accept && w_is_push;
    push_midx_d = host_mindex;

    if (s1_vld_q && s1_last_q) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PROG;
          p_d     = 5'd0;
          busy_d  = 1'b1;
        end
      end
      ST_PROG: begin
        s1_vld_d = 1'b1;
        s1_idx_d = p_q;
        p_d      = p_q + 5'd1;
        if (p_q == c_prog_last) begin
          p_d        = 5'd0;
          conf_cnt_d = 6'd0;
          len_d      = w_len_clamp;
          if (w_len_clamp == 6'd0) begin
            state_d   = ST_RUN;
            s1_last_d = 1'b1;
          end else begin
            state_d = ST_CONF;
          end
        end
      end
      ST_CONF: begin
        s1_vld_d   = 1'b1;
        s1_conf_d  = 1'b1;
        conf_cnt_d = conf_cnt_q + 6'd1;
        if (conf_cnt_q == (len_q - 6'd1)) begin
          s1_last_d  = 1'b1;
          conf_cnt_d = 6'd0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start) begin
          state_d = ST_PROG;
          p_d     = 5'd0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loader and host never overlap: host_ready waits for done, which follows the last load write
    if (s1_vld_q) begin
      if (s1_conf_q) begin
        act_d  = {2'b00, conf_data[CONF_ACT_HI -: 4]};
        din_d  = conf_data[CONF_DIN_HI:0];
        midx_d = conf_data[CONF_MIDX_HI -: 2];
      end else begin
        act_d = 6'(ACT_INSTR);
        idx_d = s1_idx_q;
        din_d = {16'h0000, prog_data};
      end
    end else if (w_accept && (host_action != 6'd0)) begin
      act_d  = host_action;
      din_d  = host_din;
      midx_d = host_mindex;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      p_q         <= 5'd0;
      conf_cnt_q  <= 6'd0;
      len_q       <= 6'd0;
      s1_vld_q    <= 1'b0;
      s1_conf_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_idx_q    <= 5'd0;
      act_q       <= 6'd0;
      idx_q       <= 5'd0;
      din_q       <= 32'd0;
      midx_q      <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      push_vld_q  <= 1'b0;
      push_midx_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      conf_cnt_q  <= conf_cnt_d;
      len_q       <= len_d;
      s1_vld_q    <= s1_vld_d;
      s1_conf_q   <= s1_conf_d;
      s1_last_q   <= s1_last_d;
      s1_idx_q    <= s1_idx_d;
      act_q       <= act_d;
      idx_q       <= idx_d;
      din_q       <= din_d;
      midx_q      <= midx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      push_vld_q  <= push_vld_d;
      push_midx_q <= push_midx_d;
    end
  end

  assign prog_addr  = p_q;
  assign conf_addr  = conf_cnt_q[4:0];
  assign host_ready = w_host_ready;
  assign pio_action = act_q;
  assign pio_index  = idx_q;
  assign pio_din    = din_q;
  assign pio_mindex = midx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_pio_loader.sv
// +----------------------------------------------------------------------+
// | tb_pio_loader : self-checking bench for pio_loader       Rev 1.0     |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_pio_loader;

  localparam int PL      = 32;
  localparam int A_PUSH  = 4;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        start;
  logic [5:0]  conf_len;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [4:0]  conf_addr;
  logic [37:0] conf_data;
  logic        host_valid;
  logic        host_ready;
  logic [5:0]  host_action;
  logic [1:0]  host_mindex;
  logic [31:0] host_din;
  logic [3:0]  tx_full;
  logic [5:0]  pio_action;
  logic [4:0]  pio_index;
  logic [31:0] pio_din;
  logic [1:0]  pio_mindex;
  logic        busy;
  logic        done;

  pio_loader #(
    .PROG_LEN  (PL),
    .CONF_DEPTH(32),
    .ACT_INSTR (1),
    .ACT_PUSH  (A_PUSH)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (start),
    .conf_len   (conf_len),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .conf_addr  (conf_addr),
    .conf_data  (conf_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_action(host_action),
    .host_mindex(host_mindex),
    .host_din   (host_din),
    .tx_full    (tx_full),
    .pio_action (pio_action),
    .pio_index  (pio_index),
    .pio_din    (pio_din),
    .pio_mindex (pio_mindex),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories feeding the loader
  logic [15:0] prog_mem [0:31];
  logic [37:0] conf_mem [0:31];
  always @(posedge clk) begin
    prog_data <= prog_mem[prog_addr];
    conf_data <= conf_mem[conf_addr];
  end

  typedef struct packed {
    logic [5:0]  act;
    logic [4:0]  idx;
    logic [31:0] din;
    logic [1:0]  midx;
  } wr_t;

  int   errors = 0;
  int   checks = 0;

  // Host-side reference state
  logic       exp_wr_vld;
  wr_t        exp_wr;
  logic       push_prev;
  logic [1:0] push_midx;

  // Full load from start pulse: writes expected at cycles 3..total+2 after the pulse
  task automatic do_load(input int len, input logic hv);
    wr_t q[$];
    wr_t e;
    wr_t got;
    int  total;
    logic e_done, e_busy;
    for (int i = 0; i < PL; i++) begin
      e.act = 6'd1; e.idx = 5'(i); e.din = {16'h0, prog_mem[i]}; e.midx = 2'd0;
      q.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      e.act = {2'b00, conf_mem[i][35:32]}; e.idx = 5'd0;
      e.din = conf_mem[i][31:0]; e.midx = conf_mem[i][37:36];
      q.push_back(e);
    end
    total = q.size();
    @(negedge clk);
    start = 1'b1; conf_len = 6'(len); tx_full = 4'd0;
    host_valid = hv; host_action = 6'd7; host_mindex = 2'd1; host_din = $urandom;
    #1;
    checks++;
    if (host_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_ready: host_ready=%b required 0", host_ready);
    end
    for (int n = 1; n <= total + 3; n++) begin
      @(negedge clk);
      start = 1'b0; host_valid = 1'b0; host_action = 6'd0;
      #1;
      got    = {pio_action, pio_index, pio_din, pio_mindex};
      e_done = (n >= total + 2);
      e_busy = (n < total + 2);
      checks++;
      if (n >= 3 && n - 3 < total) begin
        e = q[n-3];
        if (got !== e || done !== e_done || busy !== e_busy || host_ready !== e_done) begin
          errors++;
          $display("FAIL load_write n=%0d: act=%h idx=%h din=%h midx=%h done=%b busy=%b rdy=%b required act=%h idx=%h din=%h midx=%h done=%b busy=%b rdy=%b",
                   n, pio_action, pio_index, pio_din, pio_mindex, done, busy, host_ready,
                   e.act, e.idx, e.din, e.midx, e_done, e_busy, e_done);
        end
      end else begin
        if (pio_action !== 6'd0 || done !== e_done || busy !== e_busy || host_ready !== e_done) begin
          errors++;
          $display("FAIL load_idle n=%0d: act=%h done=%b busy=%b rdy=%b required act=00 done=%b busy=%b rdy=%b",
                   n, pio_action, done, busy, host_ready, e_done, e_busy, e_done);
        end
      end
    end
    exp_wr_vld = 1'b0;
    push_prev  = 1'b0;
  endtask

  // One RUN cycle: check last cycle's write, drive a command, check host_ready
  task automatic host_step(input logic v, input logic [5:0] a, input logic [1:0] m,
                           input logic [31:0] d, input logic [3:0] tf);
    logic e_rdy;
    logic acc;
    @(negedge clk);
    checks++;
    if (exp_wr_vld) begin
      if (pio_action !== exp_wr.act || pio_index !== 5'd0 || pio_din !== exp_wr.din ||
          pio_mindex !== exp_wr.midx) begin
        errors++;
        $display("FAIL host_write: act=%h idx=%h din=%h midx=%h required act=%h idx=00 din=%h midx=%h",
                 pio_action, pio_index, pio_din, pio_mindex, exp_wr.act, exp_wr.din, exp_wr.midx);
      end
    end else if (pio_action !== 6'd0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL host_idle: act=%h done=%b busy=%b required act=00 done=1 busy=0",
               pio_action, done, busy);
    end
    host_valid = v; host_action = a; host_mindex = m; host_din = d; tx_full = tf;
    #1;
    e_rdy = !((int'(a) == A_PUSH) && (tf[m] || (push_prev && push_midx == m)));
    checks++;
    if (host_ready !== e_rdy) begin
      errors++;
      $display("FAIL host_ready: act=%0d m=%0d tx_full=%b got=%b required=%b",
               a, m, tf, host_ready, e_rdy);
    end
    acc        = v && e_rdy;
    exp_wr_vld = acc && (a != 6'd0);
    exp_wr.act = a; exp_wr.idx = 5'd0; exp_wr.din = d; exp_wr.midx = m;
    push_prev  = acc && (int'(a) == A_PUSH);
    push_midx  = m;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; start = 1'b0; conf_len = 6'd0; host_valid = 1'b0;
    host_action = 6'd0; host_mindex = 2'd0; host_din = 32'd0; tx_full = 4'd0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    checks++;
    if ({pio_action, pio_index, pio_din, pio_mindex, prog_addr, conf_addr, busy, done, host_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: act=%h idx=%h din=%h midx=%h paddr=%h caddr=%h busy=%b done=%b rdy=%b required all 0",
               pio_action, pio_index, pio_din, pio_mindex, prog_addr, conf_addr, busy, done, host_ready);
    end
    n_reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || host_ready !== 1'b0 || pio_action !== 6'd0) begin
      errors++;
      $display("FAIL idle_state: busy=%b done=%b rdy=%b act=%h required 0", busy, done, host_ready, pio_action);
    end
  endtask

  task automatic test_prog_only();
    for (int i = 0; i < 32; i++) prog_mem[i] = 16'hA000 + 16'(i);
    do_load(0, 1'b0);
  endtask

  task automatic test_conf();
    conf_mem[0] = {2'd1, 4'd2, 32'h11};
    conf_mem[1] = {2'd2, 4'd3, 32'h22};
    conf_mem[2] = {2'd0, 4'd5, 32'h33};
    do_load(3, 1'b0);
  endtask

  task automatic test_host_push();
    host_step(1'b1, 6'd4, 2'd2, 32'hDEAD0001, 4'b0100);
    host_step(1'b1, 6'd4, 2'd2, 32'hDEAD0002, 4'b0000);
    host_step(1'b1, 6'd4, 2'd2, 32'hDEAD0003, 4'b0000);
    host_step(1'b1, 6'd4, 2'd2, 32'hDEAD0004, 4'b0000);
    host_step(1'b1, 6'd4, 2'd3, 32'hDEAD0005, 4'b0000);
    host_step(1'b0, 6'd0, 2'd0, 32'd0, 4'b0000);
  endtask

  task automatic test_back_to_back();
    host_step(1'b1, 6'd7, 2'd0, 32'h1234_5678, 4'b1111);
    host_step(1'b1, 6'd7, 2'd1, 32'h9ABC_DEF0, 4'b1111);
    host_step(1'b1, 6'd0, 2'd3, 32'hFFFF_FFFF, 4'b0000);
    host_step(1'b0, 6'd0, 2'd0, 32'd0, 4'b0000);
  endtask

  task automatic test_random_host(input int n);
    logic [5:0] a;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 6'd0;
        1:       a = 6'(A_PUSH);
        2:       a = 6'd7;
        default: a = 6'($urandom_range(1, 63));
      endcase
      host_step($urandom_range(0, 3) != 0, a, 2'($urandom_range(0, 3)), $urandom,
                4'($urandom & $urandom));
    end
    host_step(1'b0, 6'd0, 2'd0, 32'd0, 4'b0000);
  endtask

  task automatic test_random_load();
    for (int i = 0; i < 32; i++) begin
      prog_mem[i] = 16'($urandom);
      conf_mem[i] = {6'($urandom), $urandom};
    end
    do_load($urandom_range(1, 32), 1'b0);
  endtask

  task automatic test_reset_midload();
    @(negedge clk);
    start = 1'b1; conf_len = 6'd0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    checks++;
    if (pio_action !== 6'd1 || pio_index !== 5'd10 || pio_din !== {16'h0, prog_mem[10]}) begin
      errors++;
      $display("FAIL midload_write10: act=%h idx=%h din=%h required act=01 idx=0a din=%h",
               pio_action, pio_index, pio_din, {16'h0, prog_mem[10]});
    end
    n_reset = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({pio_action, pio_index, pio_din, pio_mindex, prog_addr, conf_addr, busy, done, host_ready} !== '0) begin
      errors++;
      $display("FAIL midload_reset: act=%h idx=%h din=%h midx=%h paddr=%h caddr=%h busy=%b done=%b rdy=%b required all 0",
               pio_action, pio_index, pio_din, pio_mindex, prog_addr, conf_addr, busy, done, host_ready);
    end
    n_reset = 1'b1;
    do_load(0, 1'b0);
  endtask

  task automatic test_start_in_run();
    test_random_host(10);
    do_load(2, 1'b1);
  endtask

  initial begin
    exp_wr_vld = 1'b0;
    exp_wr     = '0;
    push_prev  = 1'b0;
    push_midx  = 2'd0;
    for (int i = 0; i < 32; i++) conf_mem[i] = '0;
    test_reset();
    test_prog_only();
    test_host_push();
    test_back_to_back();
    test_conf();
    test_random_host(150);
    test_random_load();
    test_random_host(100);
    test_reset_midload();
    test_start_in_run();
    test_random_host(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
